// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - Dispatcher/RoB facing bundle of the architectural register file.
interface register_file_if #(
  parameter int RoB_WIDTH = 3
);
  logic                 rdy_in;
  logic                 commit_en;
  logic [5:0]           commit_reg;
  logic [RoB_WIDTH-1:0] commit_index;
  logic [31:0]          commit_data;
  logic                 rename_en;
  logic [4:0]           rename_reg;
  logic [RoB_WIDTH-1:0] rename_index;
  logic                 flush_in;
  logic [4:0]           rs1_reg;
  logic [4:0]           rs2_reg;
  logic                 rs1_busy;
  logic [RoB_WIDTH-1:0] rs1_tag;
  logic [31:0]          rs1_value;
  logic                 rs2_busy;
  logic [RoB_WIDTH-1:0] rs2_tag;
  logic [31:0]          rs2_value;
  logic [5:0]           busy_count;

  modport master (
    output rdy_in, commit_en, commit_reg, commit_index, commit_data,
    output rename_en, rename_reg, rename_index, flush_in, rs1_reg, rs2_reg,
    input  rs1_busy, rs1_tag, rs1_value, rs2_busy, rs2_tag, rs2_value, busy_count
  );

  modport slave (
    input  rdy_in, commit_en, commit_reg, commit_index, commit_data,
    input  rename_en, rename_reg, rename_index, flush_in, rs1_reg, rs2_reg,
    output rs1_busy, rs1_tag, rs1_value, rs2_busy, rs2_tag, rs2_value, busy_count
  );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - Architectural register file x0..x31 with per-register RoB rename tags.
module register_file #(
  parameter int RoB_WIDTH = 3
) (
  input logic           clk_in,
  input logic           rst_in,
  register_file_if.slave rf
);

  logic [31:0]          value_q [32];
  logic [31:0]          value_d [32];
  logic [31:0]          busy_q;
  logic [31:0]          busy_d;
  logic [RoB_WIDTH-1:0] tag_q   [32];
  logic [RoB_WIDTH-1:0] tag_d   [32];
  logic [5:0]           busy_count_q;
  logic [5:0]           busy_count_d;

  logic [4:0] commit_r;
  logic       unused_commit_hi;

  assign commit_r         = rf.commit_reg[4:0];
  assign unused_commit_hi = rf.commit_reg[5];

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      value_d[i] = value_q[i];
      tag_d[i]   = tag_q[i];
    end
    busy_d       = busy_q;
    busy_count_d = '0;

    if (rf.commit_en && commit_r != 5'd0) begin
      value_d[commit_r] = rf.commit_data;
      // A younger rename owns the register: keep its busy/tag, write value only.
      if (busy_q[commit_r] && tag_q[commit_r] == rf.commit_index) begin
        busy_d[commit_r] = 1'b0;
        tag_d[commit_r]  = '0;
      end
    end

    if (rf.rename_en && rf.rename_reg != 5'd0 && !rf.flush_in) begin
      busy_d[rf.rename_reg] = 1'b1;
      tag_d[rf.rename_reg]  = rf.rename_index;
    end

    if (rf.flush_in) begin
      busy_d = '0;
      for (int i = 0; i < 32; i++) tag_d[i] = '0;
    end

    for (int i = 0; i < 32; i++) busy_count_d = busy_count_d + 6'(busy_d[i]);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
    end else if (rf.rdy_in) begin
      for (int i = 0; i < 32; i++) begin
        value_q[i] <= value_d[i];
        tag_q[i]   <= tag_d[i];
      end
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  // Commit bypass lets the Dispatcher see a result in the cycle it retires.
  function automatic logic [RoB_WIDTH+32:0] read_port(input logic [4:0] rs);
    logic hit;
    hit = rf.rdy_in && busy_q[rs] && rf.commit_en && commit_r == rs &&
          tag_q[rs] == rf.commit_index;
    if (hit) return {1'b0, {RoB_WIDTH{1'b0}}, rf.commit_data};
    return {busy_q[rs], tag_q[rs], value_q[rs]};
  endfunction

  assign {rf.rs1_busy, rf.rs1_tag, rf.rs1_value} = read_port(rf.rs1_reg);
  assign {rf.rs2_busy, rf.rs2_tag, rf.rs2_value} = read_port(rf.rs2_reg);
  assign rf.busy_count = busy_count_q;

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - Directed self-checking bench for register_file.
module tb_register_file;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  int   errors = 0;
  int   checks = 0;

  register_file_if #(.RoB_WIDTH(3)) rf_if ();

  register_file #(.RoB_WIDTH(3)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rf     (rf_if)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rf_if.commit_en    = 1'b0;
    rf_if.commit_reg   = '0;
    rf_if.commit_index = '0;
    rf_if.commit_data  = '0;
    rf_if.rename_en    = 1'b0;
    rf_if.rename_reg   = '0;
    rf_if.rename_index = '0;
    rf_if.flush_in     = 1'b0;
  endtask

  task automatic rename(input logic [4:0] r, input logic [2:0] idx);
    idle();
    rf_if.rename_en    = 1'b1;
    rf_if.rename_reg   = r;
    rf_if.rename_index = idx;
    step();
    idle();
  endtask

  task automatic commit(input logic [5:0] r, input logic [2:0] idx, input logic [31:0] d);
    idle();
    rf_if.commit_en    = 1'b1;
    rf_if.commit_reg   = r;
    rf_if.commit_index = idx;
    rf_if.commit_data  = d;
    step();
    idle();
  endtask

  initial begin
    idle();
    rf_if.rdy_in  = 1'b1;
    rf_if.rs1_reg = 5'd5;
    rf_if.rs2_reg = 5'd0;
    step();
    step();
    chk("reset_count", 32'(rf_if.busy_count), 32'd0);
    chk("reset_busy", 32'(rf_if.rs1_busy), 32'd0);
    rst_in = 1'b1;
    step();

    // T2: rename then matching commit, with same-cycle bypass
    rename(5'd5, 3'd3);
    chk("t2_busy", 32'(rf_if.rs1_busy), 32'd1);
    chk("t2_tag", 32'(rf_if.rs1_tag), 32'd3);
    chk("t2_count1", 32'(rf_if.busy_count), 32'd1);
    rf_if.commit_en    = 1'b1;
    rf_if.commit_reg   = 6'd5;
    rf_if.commit_index = 3'd3;
    rf_if.commit_data  = 32'hDEADBEEF;
    #1;
    chk("t2_bypass_busy", 32'(rf_if.rs1_busy), 32'd0);
    chk("t2_bypass_val", rf_if.rs1_value, 32'hDEADBEEF);
    step();
    idle();
    #1;
    chk("t2_val", rf_if.rs1_value, 32'hDEADBEEF);
    chk("t2_busy_clr", 32'(rf_if.rs1_busy), 32'd0);
    chk("t2_count0", 32'(rf_if.busy_count), 32'd0);

    // T3: stale commit writes value only
    rename(5'd5, 3'd3);
    rename(5'd5, 3'd6);
    commit(6'd5, 3'd3, 32'd1);
    chk("t3_val1", rf_if.rs1_value, 32'd1);
    chk("t3_busy1", 32'(rf_if.rs1_busy), 32'd1);
    chk("t3_tag6", 32'(rf_if.rs1_tag), 32'd6);
    commit(6'd5, 3'd6, 32'd2);
    chk("t3_val2", rf_if.rs1_value, 32'd2);
    chk("t3_busy0", 32'(rf_if.rs1_busy), 32'd0);

    // T4: commit + rename of x7 in the same cycle
    rf_if.rs2_reg = 5'd7;
    rename(5'd7, 3'd2);
    rf_if.commit_en    = 1'b1;
    rf_if.commit_reg   = 6'd7;
    rf_if.commit_index = 3'd2;
    rf_if.commit_data  = 32'h12345678;
    rf_if.rename_en    = 1'b1;
    rf_if.rename_reg   = 5'd7;
    rf_if.rename_index = 3'd4;
    #1;
    chk("t4_bypass_busy", 32'(rf_if.rs2_busy), 32'd0);
    chk("t4_bypass_val", rf_if.rs2_value, 32'h12345678);
    step();
    idle();
    #1;
    chk("t4_busy", 32'(rf_if.rs2_busy), 32'd1);
    chk("t4_tag", 32'(rf_if.rs2_tag), 32'd4);
    chk("t4_val", rf_if.rs2_value, 32'h12345678);
    commit(6'd7, 3'd4, 32'd9);
    chk("t4_count0", 32'(rf_if.busy_count), 32'd0);

    // T5: x0 is hardwired; commit_reg bit5 is ignored
    rf_if.rs1_reg = 5'd0;
    rf_if.rs2_reg = 5'd3;
    rename(5'd0, 3'd1);
    chk("t5_count", 32'(rf_if.busy_count), 32'd0);
    commit(6'd0, 3'd1, 32'd5);
    commit(6'h23, 3'd0, 32'hAA);
    chk("t5_x0_busy", 32'(rf_if.rs1_busy), 32'd0);
    chk("t5_x0_tag", 32'(rf_if.rs1_tag), 32'd0);
    chk("t5_x0_val", rf_if.rs1_value, 32'd0);
    chk("t5_bit5_val", rf_if.rs2_value, 32'hAA);

    // T6: pause, then flush with a dropped rename and a retained commit
    rename(5'd1, 3'd1);
    rename(5'd2, 3'd2);
    rename(5'd3, 3'd3);
    chk("t6_count3", 32'(rf_if.busy_count), 32'd3);
    rf_if.rdy_in       = 1'b0;
    rf_if.rename_en    = 1'b1;
    rf_if.rename_reg   = 5'd4;
    rf_if.rename_index = 3'd5;
    rf_if.commit_en    = 1'b1;
    rf_if.commit_reg   = 6'd1;
    rf_if.commit_index = 3'd1;
    rf_if.commit_data  = 32'd77;
    step();
    idle();
    rf_if.rdy_in  = 1'b1;
    rf_if.rs1_reg = 5'd1;
    rf_if.rs2_reg = 5'd4;
    #1;
    chk("t6_hold_count", 32'(rf_if.busy_count), 32'd3);
    chk("t6_hold_x1busy", 32'(rf_if.rs1_busy), 32'd1);
    chk("t6_hold_x1val", rf_if.rs1_value, 32'd0);
    chk("t6_hold_x4busy", 32'(rf_if.rs2_busy), 32'd0);
    rf_if.flush_in     = 1'b1;
    rf_if.rename_en    = 1'b1;
    rf_if.rename_reg   = 5'd4;
    rf_if.rename_index = 3'd5;
    rf_if.commit_en    = 1'b1;
    rf_if.commit_reg   = 6'd2;
    rf_if.commit_index = 3'd7;
    rf_if.commit_data  = 32'h55;
    step();
    idle();
    #1;
    chk("t6_flush_count", 32'(rf_if.busy_count), 32'd0);
    chk("t6_x1_busy", 32'(rf_if.rs1_busy), 32'd0);
    chk("t6_x4_busy", 32'(rf_if.rs2_busy), 32'd0);
    rf_if.rs1_reg = 5'd2;
    rf_if.rs2_reg = 5'd3;
    #1;
    chk("t6_x2_val", rf_if.rs1_value, 32'h55);
    chk("t6_x2_tag", 32'(rf_if.rs1_tag), 32'd0);
    chk("t6_x3_val", rf_if.rs2_value, 32'hAA);

    // T1: asynchronous reset mid-run with x5 busy
    rf_if.rs1_reg = 5'd5;
    rename(5'd5, 3'd2);
    chk("t1_pre_busy", 32'(rf_if.rs1_busy), 32'd1);
    #2;
    rst_in = 1'b0;
    #1;
    chk("t1_busy", 32'(rf_if.rs1_busy), 32'd0);
    chk("t1_val", rf_if.rs1_value, 32'd0);
    chk("t1_count", 32'(rf_if.busy_count), 32'd0);
    chk("t1_x3_val", rf_if.rs2_value, 32'd0);
    step();
    rst_in = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
